// File: rtl/matmul_pkg.sv
// Shared types and default array geometry for the matmul sequencer slice.
package matmul_pkg;

    localparam int MAT_N     = 4;
    localparam int DRAIN_CYC = 7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        STORE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Control/status and BRAM address bundle between apb_slave, the sequencer and the BRAMs.
interface matmul_seq_ctrl_if #(
    parameter int AWIDTH            = 10,
    parameter int ADDR_STRIDE_WIDTH = 8
);
    logic                         start;
    logic [AWIDTH-1:0]            address_mat_a;
    logic [AWIDTH-1:0]            address_mat_b;
    logic [AWIDTH-1:0]            address_mat_c;
    logic [ADDR_STRIDE_WIDTH-1:0] address_stride_a;
    logic [ADDR_STRIDE_WIDTH-1:0] address_stride_b;
    logic [ADDR_STRIDE_WIDTH-1:0] address_stride_c;

    logic [AWIDTH-1:0]            a_addr;
    logic [AWIDTH-1:0]            b_addr;
    logic [AWIDTH-1:0]            c_addr;
    logic                         a_en;
    logic                         b_en;
    logic                         c_we;
    logic                         busy;
    logic                         done;
    logic                         exceptions;

    modport master (
        output start, address_mat_a, address_mat_b, address_mat_c,
               address_stride_a, address_stride_b, address_stride_c,
        input  a_addr, b_addr, c_addr, a_en, b_en, c_we, busy, done, exceptions
    );

    modport slave (
        input  start, address_mat_a, address_mat_b, address_mat_c,
               address_stride_a, address_stride_b, address_stride_c,
        output a_addr, b_addr, c_addr, a_en, b_en, c_we, busy, done, exceptions
    );

endinterface

// File: rtl/matmul_addr_gen.sv
// Strided row address generator: latches base/stride on load, emits one address per step.
// Latency: addr is registered, valid the cycle after step; ovf is combinational from base/stride.
// No backpressure: step advances unconditionally; addr returns to 0 when not stepping.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int AWIDTH            = 10,
    parameter int ADDR_STRIDE_WIDTH = 8
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         load,
    input  logic                         step,
    input  logic [AWIDTH-1:0]            base,
    input  logic [ADDR_STRIDE_WIDTH-1:0] stride,
    output logic [AWIDTH-1:0]            addr,
    output logic                         ovf
);

    localparam int CW = $clog2(MAT_N);
    localparam int EW = ((AWIDTH > ADDR_STRIDE_WIDTH + CW) ? AWIDTH : ADDR_STRIDE_WIDTH + CW) + 1;

    logic [EW-1:0]                end_w;
    logic [AWIDTH-1:0]            nxt_q;
    logic [ADDR_STRIDE_WIDTH-1:0] stride_q;
    logic [AWIDTH-1:0]            cur;
    logic [ADDR_STRIDE_WIDTH-1:0] cur_stride;

    // Last row address at full width; any bit above AWIDTH means the pass would wrap.
    assign end_w = EW'(base) + EW'(stride) * EW'(MAT_N - 1);
    assign ovf   = |end_w[EW-1:AWIDTH];

    // A load and the first step may coincide, so the live base/stride bypass the latches.
    always_comb begin
        cur        = load ? base   : nxt_q;
        cur_stride = load ? stride : stride_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr     <= '0;
            nxt_q    <= '0;
            stride_q <= '0;
        end else begin
            addr     <= step ? cur : '0;
            nxt_q    <= step ? cur + AWIDTH'(cur_stride) : cur;
            stride_q <= cur_stride;
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequences one systolic matmul pass: MAT_N A/B fetches, DRAIN_CYC idle, MAT_N C stores, then done.
// Latency: first fetch one cycle after the start edge; done 2*MAT_N+DRAIN_CYC+1 cycles after it.
// No backpressure: BRAM accesses are fire-and-forget; done holds until start is dropped.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int AWIDTH            = 10,
    parameter int ADDR_STRIDE_WIDTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    matmul_seq_ctrl_if.slave  bus
);

    localparam int KW = $clog2(MAT_N);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    seq_state_t        state, next_state;
    logic [KW-1:0]     k_q, k_nxt;
    logic [DW-1:0]     dcnt_q, dcnt_nxt;
    logic              start_q;
    logic              armed_q;
    logic              exc_q, exc_nxt;
    logic              launch;
    logic              any_ovf;
    logic              ovf_a, ovf_b, ovf_c;
    logic [AWIDTH-1:0] addr_a, addr_b, addr_c;
    logic              en_q, we_q, busy_q, done_q;

    // armed_q stays low until start is seen low, so a start held across reset cannot launch.
    assign launch  = (state == IDLE) & bus.start & ~start_q & armed_q;
    assign any_ovf = ovf_a | ovf_b | ovf_c;

    always_comb begin
        next_state = state;
        k_nxt      = k_q;
        dcnt_nxt   = dcnt_q;
        exc_nxt    = exc_q;
        case (state)
            IDLE: begin
                if (launch) begin
                    exc_nxt    = any_ovf;
                    next_state = any_ovf ? DONE : FETCH;
                    k_nxt      = '0;
                end
            end
            FETCH: begin
                if (k_q == KW'(MAT_N - 1)) begin
                    next_state = DRAIN;
                    dcnt_nxt   = '0;
                end else begin
                    k_nxt = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == DW'(DRAIN_CYC - 1)) begin
                    next_state = STORE;
                    k_nxt      = '0;
                end else begin
                    dcnt_nxt = dcnt_q + DW'(1);
                end
            end
            STORE: begin
                if (k_q == KW'(MAT_N - 1)) begin
                    next_state = DONE;
                end else begin
                    k_nxt = k_q + KW'(1);
                end
            end
            DONE: begin
                if (!bus.start) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are decoded from next_state so they line up with the registered addresses.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            k_q     <= '0;
            dcnt_q  <= '0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            exc_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= next_state;
            k_q     <= k_nxt;
            dcnt_q  <= dcnt_nxt;
            start_q <= bus.start;
            armed_q <= armed_q | ~bus.start;
            exc_q   <= exc_nxt;
            en_q    <= (next_state == FETCH);
            we_q    <= (next_state == STORE);
            busy_q  <= (next_state == FETCH) | (next_state == DRAIN) | (next_state == STORE);
            done_q  <= (next_state == DONE);
        end
    end

    matmul_addr_gen #(.AWIDTH(AWIDTH), .ADDR_STRIDE_WIDTH(ADDR_STRIDE_WIDTH)) u_gen_a (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .load    (launch),
        .step    (next_state == FETCH),
        .base    (bus.address_mat_a),
        .stride  (bus.address_stride_a),
        .addr    (addr_a),
        .ovf     (ovf_a)
    );

    matmul_addr_gen #(.AWIDTH(AWIDTH), .ADDR_STRIDE_WIDTH(ADDR_STRIDE_WIDTH)) u_gen_b (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .load    (launch),
        .step    (next_state == FETCH),
        .base    (bus.address_mat_b),
        .stride  (bus.address_stride_b),
        .addr    (addr_b),
        .ovf     (ovf_b)
    );

    matmul_addr_gen #(.AWIDTH(AWIDTH), .ADDR_STRIDE_WIDTH(ADDR_STRIDE_WIDTH)) u_gen_c (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .load    (launch),
        .step    (next_state == STORE),
        .base    (bus.address_mat_c),
        .stride  (bus.address_stride_c),
        .addr    (addr_c),
        .ovf     (ovf_c)
    );

    assign bus.a_addr     = addr_a;
    assign bus.b_addr     = addr_b;
    assign bus.c_addr     = addr_c;
    assign bus.a_en       = en_q;
    assign bus.b_en       = en_q;
    assign bus.c_we       = we_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.exceptions = exc_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench: a timeline model of each pass predicts every cycle's outputs; a negedge monitor checks them.
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    localparam int AW      = 10;
    localparam int SW      = 8;
    localparam int N       = MAT_N;
    localparam int D       = DRAIN_CYC;
    localparam int RUN_LEN = 2 * N + D;
    localparam int AMAX    = (1 << AW) - 1;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    matmul_seq_ctrl_if #(.AWIDTH(AW), .ADDR_STRIDE_WIDTH(SW)) bus ();

    matmul_seq_ctrl #(.AWIDTH(AW), .ADDR_STRIDE_WIDTH(SW)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    typedef struct {
        bit    a_en;
        int    a_addr;
        bit    b_en;
        int    b_addr;
        bit    c_we;
        int    c_addr;
        bit    busy;
        bit    done;
        bit    exc;
        string tag;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    n_cmp = 0;
    int    n_bad = 0;
    string cur_tag = "reset";

    // Reference model: elapsed cycles since launch (m_t), or parked in done, or idle.
    int m_t = -1;
    bit m_done, m_exc, m_armed, m_sprev;
    int m_ba, m_bb, m_bc, m_sa, m_sb, m_sc;

    task automatic model_reset();
        m_t     = -1;
        m_done  = 1'b0;
        m_exc   = 1'b0;
        m_armed = 1'b0;
        m_sprev = 1'b0;
    endtask

    task automatic model_edge(input bit s);
        int ea, eb, ec;
        if (m_done) begin
            if (!s) m_done = 1'b0;
        end else if (m_t >= 0) begin
            m_t++;
            if (m_t == RUN_LEN) begin
                m_t    = -1;
                m_done = 1'b1;
            end
        end else if (s && !m_sprev && m_armed) begin
            m_ba = int'(bus.address_mat_a);    m_sa = int'(bus.address_stride_a);
            m_bb = int'(bus.address_mat_b);    m_sb = int'(bus.address_stride_b);
            m_bc = int'(bus.address_mat_c);    m_sc = int'(bus.address_stride_c);
            ea = m_ba + (N - 1) * m_sa;
            eb = m_bb + (N - 1) * m_sb;
            ec = m_bc + (N - 1) * m_sc;
            if (ea > AMAX || eb > AMAX || ec > AMAX) begin
                m_exc  = 1'b1;
                m_done = 1'b1;
            end else begin
                m_exc = 1'b0;
                m_t   = 0;
            end
        end
        if (!s) m_armed = 1'b1;
        m_sprev = s;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.a_en = 0; e.a_addr = 0; e.b_en = 0; e.b_addr = 0;
        e.c_we = 0; e.c_addr = 0;
        e.busy = (m_t >= 0);
        e.done = m_done;
        e.exc  = m_exc;
        e.tag  = cur_tag;
        if (m_t >= 0 && m_t < N) begin
            e.a_en = 1; e.a_addr = m_ba + m_t * m_sa;
            e.b_en = 1; e.b_addr = m_bb + m_t * m_sb;
        end
        if (m_t >= N + D && m_t < RUN_LEN) begin
            e.c_we = 1; e.c_addr = m_bc + (m_t - N - D) * m_sc;
        end
        return e;
    endfunction

    // One clock: advance the model at the edge, optionally change reset just after it, queue the expectation.
    task automatic tick(input bit assert_rst = 1'b0, input bit release_rst = 1'b0);
        @(posedge PCLK);
        if (PRESETn) model_edge(bus.start);
        else         model_reset();
        #1;
        if (assert_rst) begin
            PRESETn = 1'b0;
            model_reset();
        end
        if (release_rst) PRESETn = 1'b1;
        sb_q.push_back(model_out());
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_cfg(input int ba, input int bb, input int bc,
                           input int sa, input int sb, input int sc);
        bus.address_mat_a    = AW'(ba);
        bus.address_mat_b    = AW'(bb);
        bus.address_mat_c    = AW'(bc);
        bus.address_stride_a = SW'(sa);
        bus.address_stride_b = SW'(sb);
        bus.address_stride_c = SW'(sc);
    endtask

    function automatic int pick_base(input int stride);
        int lim;
        lim = AMAX - (N - 1) * stride;
        if ($urandom_range(0, 5) == 0 || lim < 0) return int'($urandom_range(900, AMAX));
        return int'($urandom_range(0, lim));
    endfunction

    always @(negedge PCLK) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (bus.a_en !== mon_e.a_en || int'(bus.a_addr) != mon_e.a_addr ||
                bus.b_en !== mon_e.b_en || int'(bus.b_addr) != mon_e.b_addr ||
                bus.c_we !== mon_e.c_we || int'(bus.c_addr) != mon_e.c_addr ||
                bus.busy !== mon_e.busy || bus.done !== mon_e.done ||
                bus.exceptions !== mon_e.exc) begin
                n_bad++;
                $display("FAIL %s @%0t: got a %0d/%0d b %0d/%0d c %0d/%0d busy %0d done %0d exc %0d; need a %0d/%0d b %0d/%0d c %0d/%0d busy %0d done %0d exc %0d",
                         mon_e.tag, $time,
                         bus.a_en, bus.a_addr, bus.b_en, bus.b_addr, bus.c_we, bus.c_addr,
                         bus.busy, bus.done, bus.exceptions,
                         mon_e.a_en, mon_e.a_addr, mon_e.b_en, mon_e.b_addr, mon_e.c_we, mon_e.c_addr,
                         mon_e.busy, mon_e.done, mon_e.exc);
            end
        end
    end

    initial begin
        int sa, sb, sc;
        bus.start = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        model_reset();

        cur_tag = "reset";
        run(3);
        tick(1'b0, 1'b1);
        run(2);

        cur_tag = "basic_4_8_12";
        set_cfg(4, 8, 12, 1, 1, 1);
        bus.start = 1'b1; run(20);
        bus.start = 1'b0; run(3);

        cur_tag = "rerun_basic";
        bus.start = 1'b1; run(20);
        bus.start = 1'b0; run(2);

        cur_tag = "strided";
        set_cfg(0, 16, 32, 4, 2, 8);
        bus.start = 1'b1; run(18);
        bus.start = 1'b0; run(2);

        cur_tag = "overflow_1021";
        set_cfg(1021, 8, 12, 1, 1, 1);
        bus.start = 1'b1; run(4);
        bus.start = 1'b0; run(2);

        cur_tag = "edge_1020";
        set_cfg(1020, 8, 12, 1, 1, 1);
        bus.start = 1'b1; run(18);
        bus.start = 1'b0; run(2);

        cur_tag = "reset_in_drain";
        set_cfg(4, 8, 12, 1, 1, 1);
        bus.start = 1'b1; run(7);
        tick(1'b1, 1'b0);
        tick();
        tick(1'b0, 1'b1);
        run(20);
        cur_tag = "relaunch_after_reset";
        bus.start = 1'b0; run(2);
        bus.start = 1'b1; run(18);
        bus.start = 1'b0; run(2);

        cur_tag = "toggle_in_fetch";
        set_cfg(100, 200, 300, 3, 0, 5);
        bus.start = 1'b1; tick();
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        bus.start = 1'b0; run(20);

        cur_tag = "random";
        for (int r = 0; r < 40; r++) begin
            sa = int'($urandom_range(0, 255));
            sb = int'($urandom_range(0, 255));
            sc = int'($urandom_range(0, 255));
            set_cfg(pick_base(sa), pick_base(sb), pick_base(sc), sa, sb, sc);
            bus.start = 1'b1;
            if (r % 10 == 7) begin
                run(int'($urandom_range(1, 14)));
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b1);
                run(3);
            end else begin
                run(int'($urandom_range(1, 22)));
            end
            bus.start = 1'b0;
            run(int'($urandom_range(1, 4)));
        end

        bus.start = 1'b0;
        run(RUN_LEN + 3);
        repeat (2) @(negedge PCLK);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
